// File: rtl/game_pkg.sv
// Shared game definitions: obstacle codes, sequencer states and default timing.
package game_pkg;

  localparam logic [3:0] OBST_NONE    = 4'd0;
  localparam logic [3:0] OBST_VLASERS = 4'd1;
  localparam logic [3:0] OBST_HLASERS = 4'd2;
  localparam logic [3:0] OBST_SPIKES  = 4'd3;
  localparam logic [3:0] OBST_BLOCKS  = 4'd4;

  localparam int unsigned DEF_NUM_OBSTACLES = 4;
  localparam int unsigned DEF_ROUNDS        = 16;
  localparam int unsigned DEF_GAP_CYCLES    = 32000000;
  localparam int unsigned DEF_START_TIMEOUT = 64;

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StStart,
    StWaitAck,
    StRun,
    StFinished
  } seq_state_e;

  // Code that follows `code` cyclically in 1..num: (code mod num) + 1.
  function automatic logic [3:0] next_code(input logic [3:0] code, input int unsigned num);
    if (code >= 4'(num)) begin
      return OBST_VLASERS;
    end
    return code + 4'd1;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left; advances only when step is high.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] value_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= seed;
    end else if (step) begin
      value_q <= {value_q[6:0], value_q[7] ^ value_q[5] ^ value_q[4] ^ value_q[3]};
    end
  end

  assign value = value_q;

endmodule

// File: rtl/obstacle_sequencer.sv
// Picks the next obstacle, issues its start pulse and tracks completion, time-outs and rounds.
module obstacle_sequencer
  import game_pkg::*;
#(
  parameter int unsigned NUM_OBSTACLES = DEF_NUM_OBSTACLES,
  parameter int unsigned ROUNDS        = DEF_ROUNDS,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_on,
  input  logic       menu_on,
  input  logic       play_selected,
  input  logic       obstacle_working,
  input  logic       obstacle_done,
  output logic [3:0] selected,
  output logic       start,
  output logic [7:0] round_count,
  output logic       timeout_err,
  output logic       level_done
);

  localparam logic [25:0] GapLast     = 26'(GAP_CYCLES - 1);
  localparam logic [25:0] TimeoutLast = 26'(START_TIMEOUT - 1);

  seq_state_e  state_q, state_d;
  logic [25:0] counter_q, counter_d;
  logic [3:0]  last_id_q, last_id_d;
  logic [3:0]  selected_q, selected_d;
  logic        start_q, start_d;
  logic [7:0]  round_q, round_d;
  logic        timeout_q, timeout_d;
  logic        level_done_q, level_done_d;

  logic        lfsr_step;
  logic [7:0]  lfsr_value;
  logic [3:0]  raw_id, pick_id;
  logic [7:0]  round_inc;
  logic        abort;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .seed  (LFSR_SEED),
    .value (lfsr_value)
  );

  assign abort     = menu_on | ~play_selected;
  assign raw_id    = 4'((lfsr_value & 8'(NUM_OBSTACLES - 1)) + 8'd1);
  // Never run the same obstacle twice in a row.
  assign pick_id   = (raw_id == last_id_q) ? next_code(last_id_q, NUM_OBSTACLES) : raw_id;
  assign round_inc = round_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    last_id_d    = last_id_q;
    selected_d   = selected_q;
    round_d      = round_q;
    start_d      = 1'b0;
    timeout_d    = 1'b0;
    level_done_d = 1'b0;
    lfsr_step    = 1'b0;

    if (state_q != StIdle && abort) begin
      state_d    = StIdle;
      selected_d = OBST_NONE;
      counter_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          selected_d = OBST_NONE;
          if (game_on && play_selected && !menu_on) begin
            round_d   = '0;
            counter_d = '0;
            state_d   = StGap;
          end
        end
        StGap: begin
          if (counter_q == GapLast) begin
            selected_d = pick_id;
            last_id_d  = pick_id;
            lfsr_step  = 1'b1;
            counter_d  = '0;
            state_d    = StStart;
          end else begin
            counter_d = counter_q + 26'd1;
          end
        end
        StStart: begin
          start_d   = 1'b1;
          counter_d = '0;
          state_d   = StWaitAck;
        end
        StWaitAck: begin
          if (obstacle_done) begin
            round_d    = round_inc;
            selected_d = OBST_NONE;
            counter_d  = '0;
            if (round_inc == 8'(ROUNDS)) begin
              state_d      = StFinished;
              level_done_d = 1'b1;
            end else begin
              state_d = StGap;
            end
          end else if (obstacle_working) begin
            counter_d = '0;
            state_d   = StRun;
          end else if (counter_q == TimeoutLast) begin
            timeout_d  = 1'b1;
            selected_d = OBST_NONE;
            counter_d  = '0;
            state_d    = StGap;
          end else begin
            counter_d = counter_q + 26'd1;
          end
        end
        StRun: begin
          if (obstacle_done) begin
            round_d    = round_inc;
            selected_d = OBST_NONE;
            counter_d  = '0;
            if (round_inc == 8'(ROUNDS)) begin
              state_d      = StFinished;
              level_done_d = 1'b1;
            end else begin
              state_d = StGap;
            end
          end
        end
        StFinished: begin
          level_done_d = 1'b1;
          selected_d   = OBST_NONE;
        end
        default: begin
          state_d    = StIdle;
          selected_d = OBST_NONE;
          counter_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      counter_q    <= '0;
      last_id_q    <= OBST_NONE;
      selected_q   <= OBST_NONE;
      start_q      <= 1'b0;
      round_q      <= '0;
      timeout_q    <= 1'b0;
      level_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      last_id_q    <= last_id_d;
      selected_q   <= selected_d;
      start_q      <= start_d;
      round_q      <= round_d;
      timeout_q    <= timeout_d;
      level_done_q <= level_done_d;
    end
  end

  assign selected    = selected_q;
  assign start       = start_q;
  assign round_count = round_q;
  assign timeout_err = timeout_q;
  assign level_done  = level_done_q;

endmodule

// File: tb/tb_obstacle_sequencer.sv
// Self-checking bench for obstacle_sequencer: directed vectors, corner sequences, random traffic.
module tb_obstacle_sequencer;

  localparam int GAP = 4;
  localparam int TO  = 8;
  localparam int RND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic game_on = 1'b0, menu_on = 1'b0, play_selected = 1'b0;
  logic obstacle_working = 1'b0, obstacle_done = 1'b0;

  logic [3:0] selected, c_selected;
  logic       start, c_start, timeout_err, c_timeout_err, level_done, c_level_done;
  logic [7:0] round_count, c_round_count;

  int total = 0;
  int bad = 0;

  // Reference model: per-DUT pick state, plus completed-round count.
  logic [7:0] m_lfsr [2];
  logic [3:0] m_last [2];
  int         m_round;
  logic [3:0] obs_pick0, obs_pick1;

  always #5 clk = ~clk;

  obstacle_sequencer #(
    .NUM_OBSTACLES(4), .ROUNDS(RND), .GAP_CYCLES(GAP), .START_TIMEOUT(TO), .LFSR_SEED(8'hA5)
  ) u_dut (
    .clk(clk), .rst(rst), .game_on(game_on), .menu_on(menu_on), .play_selected(play_selected),
    .obstacle_working(obstacle_working), .obstacle_done(obstacle_done),
    .selected(selected), .start(start), .round_count(round_count),
    .timeout_err(timeout_err), .level_done(level_done)
  );

  // Seed 0B gives picks 4 then raw 4 again, exercising the collision wrap to 1.
  obstacle_sequencer #(
    .NUM_OBSTACLES(4), .ROUNDS(RND), .GAP_CYCLES(GAP), .START_TIMEOUT(TO), .LFSR_SEED(8'h0B)
  ) u_dut_c (
    .clk(clk), .rst(rst), .game_on(game_on), .menu_on(menu_on), .play_selected(play_selected),
    .obstacle_working(obstacle_working), .obstacle_done(obstacle_done),
    .selected(c_selected), .start(c_start), .round_count(c_round_count),
    .timeout_err(c_timeout_err), .level_done(c_level_done)
  );

  typedef struct {
    logic       game, play, menu, working, done;
    logic [3:0] sel;
    logic       st;
    logic [7:0] rnd;
    logic       to, ld;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] s0, input logic [3:0] s1,
                           input logic st, input int rnd, input logic to, input logic ld);
    check({name, ".selected"}, 32'(selected), 32'(s0));
    check({name, ".start"}, 32'(start), 32'(st));
    check({name, ".round"}, 32'(round_count), 32'(rnd));
    check({name, ".timeout"}, 32'(timeout_err), 32'(to));
    check({name, ".level_done"}, 32'(level_done), 32'(ld));
    check({name, ".c_selected"}, 32'(c_selected), 32'(s1));
    check({name, ".c_start"}, 32'(c_start), 32'(st));
    check({name, ".c_round"}, 32'(c_round_count), 32'(rnd));
    check({name, ".c_timeout"}, 32'(c_timeout_err), 32'(to));
    check({name, ".c_level_done"}, 32'(c_level_done), 32'(ld));
  endtask

  task automatic model_reset();
    m_lfsr[0] = 8'hA5;
    m_lfsr[1] = 8'h0B;
    m_last[0] = 4'd0;
    m_last[1] = 4'd0;
    m_round   = 0;
  endtask

  task automatic model_pick(input int k, output logic [3:0] id);
    id = 4'((m_lfsr[k] % 4) + 1);
    if (id == m_last[k]) id = 4'((m_last[k] % 4) + 1);
    m_last[k] = id;
    m_lfsr[k] = {m_lfsr[k][6:0], ^(m_lfsr[k] & 8'hB8)};
  endtask

  task automatic complete_obstacle();
    m_round++;
    if (m_round == RND) begin
      check_all("complete_last", 0, 0, 0, m_round, 0, 1);
      repeat (3) begin
        tick();
        check_all("finished_hold", 0, 0, 0, m_round, 0, 1);
      end
      play_selected = 1'b0;
      repeat (2) begin
        tick();
        check_all("finished_abort", 0, 0, 0, m_round, 0, 0);
      end
      play_selected = 1'b1;
      tick();
      m_round = 0;
      check_all("new_level", 0, 0, 0, 0, 0, 0);
    end else begin
      check_all("complete", 0, 0, 0, m_round, 0, 0);
    end
  endtask

  // Entered just after the edge that puts the DUT into GAP; leaves it in the same situation.
  // mode: 0 timeout, 1 working then done, 2 done straight from WAIT_ACK,
  //       3 abort together with done in RUN, 4 async reset in WAIT_ACK.
  task automatic obstacle_cycle(input int mode, input int delay, input int run_len,
                                input bit stale);
    logic [3:0] id0, id1;
    model_pick(0, id0);
    model_pick(1, id1);
    for (int i = 1; i < GAP; i++) begin
      obstacle_done = stale && (i == 1);
      tick();
      obstacle_done = 1'b0;
      check_all("gap", 0, 0, 0, m_round, 0, 0);
    end
    tick();
    check_all("pick", id0, id1, 0, m_round, 0, 0);
    obs_pick0 = selected;
    obs_pick1 = c_selected;
    obstacle_done = stale;
    tick();
    obstacle_done = 1'b0;
    check_all("start", id0, id1, 1, m_round, 0, 0);
    if (mode == 0) begin
      for (int i = 0; i < TO - 1; i++) begin
        tick();
        check_all("wait", id0, id1, 0, m_round, 0, 0);
      end
      tick();
      check_all("timeout", 0, 0, 0, m_round, 1, 0);
    end else if (mode == 4) begin
      repeat (2) begin
        tick();
        check_all("wait", id0, id1, 0, m_round, 0, 0);
      end
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check_all("after_rst", 0, 0, 0, 0, 0, 0);
    end else begin
      repeat (delay) begin
        tick();
        check_all("wait", id0, id1, 0, m_round, 0, 0);
      end
      if (mode != 2) begin
        obstacle_working = 1'b1;
        tick();
        check_all("run", id0, id1, 0, m_round, 0, 0);
        repeat (run_len) begin
          obstacle_working = ($urandom_range(0, 3) != 0);
          tick();
          check_all("run", id0, id1, 0, m_round, 0, 0);
        end
      end
      if (mode == 3) menu_on = 1'b1;
      obstacle_done = 1'b1;
      tick();
      obstacle_done = 1'b0;
      obstacle_working = 1'b0;
      if (mode == 3) begin
        check_all("abort_done", 0, 0, 0, m_round, 0, 0);
        repeat (3) begin
          tick();
          check_all("aborted_idle", 0, 0, 0, m_round, 0, 0);
        end
        menu_on = 1'b0;
        tick();
        m_round = 0;
        check_all("restart", 0, 0, 0, 0, 0, 0);
      end else begin
        complete_obstacle();
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Directed first obstacle: inputs {game, play, menu, working, done} -> outputs after the edge.
    for (int i = 0; i < 10; i++) begin
      tbl[i] = '{game: 1'b1, play: 1'b1, menu: 1'b0, working: 1'b0, done: 1'b0,
                 sel: 4'd0, st: 1'b0, rnd: 8'd0, to: 1'b0, ld: 1'b0};
    end
    tbl[4].sel = 4'd2;
    tbl[5].sel = 4'd2;  tbl[5].st = 1'b1;
    tbl[6].sel = 4'd2;
    tbl[7].sel = 4'd2;  tbl[7].working = 1'b1;
    tbl[8].sel = 4'd2;  tbl[8].working = 1'b1;
    tbl[9].working = 1'b1;  tbl[9].done = 1'b1;  tbl[9].rnd = 8'd1;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1. Table-driven start-up and first obstacle.
    for (int i = 0; i < 10; i++) begin
      game_on = tbl[i].game;
      play_selected = tbl[i].play;
      menu_on = tbl[i].menu;
      obstacle_working = tbl[i].working;
      obstacle_done = tbl[i].done;
      tick();
      check($sformatf("vec%0d.selected", i), 32'(selected), 32'(tbl[i].sel));
      check($sformatf("vec%0d.start", i), 32'(start), 32'(tbl[i].st));
      check($sformatf("vec%0d.round", i), 32'(round_count), 32'(tbl[i].rnd));
      check($sformatf("vec%0d.timeout", i), 32'(timeout_err), 32'(tbl[i].to));
      check($sformatf("vec%0d.level_done", i), 32'(level_done), 32'(tbl[i].ld));
    end
    obstacle_working = 1'b0;
    obstacle_done = 1'b0;
    model_pick(0, obs_pick0);
    model_pick(1, obs_pick1);
    m_round = 1;

    // 2. Remaining rounds of the level: picks 3 then 2, level_done held.
    obstacle_cycle(1, 1, 9, 0);
    check("seq_pick2", 32'(obs_pick0), 32'd3);
    obstacle_cycle(1, 1, 9, 0);
    check("seq_pick3", 32'(obs_pick0), 32'd2);

    // 3. Timeout after reset, then next pick; 5. collision in the second DUT.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    check_all("reentry", 0, 0, 0, 0, 0, 0);
    obstacle_cycle(0, 0, 0, 0);
    check("timeout_pick_first", 32'(obs_pick0), 32'd2);
    check("collision_first", 32'(obs_pick1), 32'd4);
    obstacle_cycle(1, 7, 2, 0);
    check("timeout_pick_next", 32'(obs_pick0), 32'd3);
    check("collision_wrap", 32'(obs_pick1), 32'd1);

    // 4. menu_on with done in RUN.
    obstacle_cycle(3, 2, 3, 0);

    // 6. Async reset in WAIT_ACK, then the LFSR must restart from its seed.
    obstacle_cycle(4, 0, 0, 0);
    obstacle_cycle(2, 3, 0, 1);
    check("post_reset_pick", 32'(obs_pick0), 32'd2);

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      int r;
      int mode;
      r = int'($urandom_range(0, 9));
      mode = (r < 2) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      obstacle_cycle(mode, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, 12)),
                     bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
